// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared state encoding and port index constants for
// the 1-to-2 packet stream demultiplexer.
package stream_demux_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/stream_demux_out_reg.sv
// stream_demux_out_reg: one-entry registered output buffer. A load always
// wins over a drain, so a simultaneous drain and load keeps the entry valid
// with the new beat, allowing one beat per cycle.
module stream_demux_out_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  // Buffer entry: reset clears, load captures, handshake without load empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      last  <= in_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// stream_demux_1to2: packet-aware 1-to-2 valid/ready demultiplexer.
// The route is picked from s_sel on the first beat of each packet and held
// until the last beat. Each output is driven by a one-entry register.
// Optional per-port completed-packet counters: define STREAM_DEMUX_PKT_CNT_EN.
module stream_demux_1to2
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_sel,
  output logic              m0_valid,
  input  logic              m0_ready,
  output logic [DATA_W-1:0] m0_data,
  output logic              m0_last,
  output logic              m1_valid,
  input  logic              m1_ready,
  output logic [DATA_W-1:0] m1_data,
  output logic              m1_last,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  state_t state;
  logic   route;
  logic   tgt;
  logic   tgt_valid;
  logic   tgt_ready;
  logic   accept;
  logic   load0;
  logic   load1;

  // Effective target and input ready; independent of s_valid.
  always_comb begin
    tgt       = (state == ST_IDLE) ? s_sel : route;
    tgt_valid = (tgt == PORT1) ? m1_valid : m0_valid;
    tgt_ready = (tgt == PORT1) ? m1_ready : m0_ready;
    s_ready   = !tgt_valid || tgt_ready;
    accept    = s_valid && s_ready;
    load0     = accept && (tgt == PORT0);
    load1     = accept && (tgt == PORT1);
  end

  // Packet FSM and route register; the route only changes on a first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      route <= PORT0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        route <= s_sel;
      end
      state <= s_last ? ST_IDLE : ST_ACTIVE;
    end
  end

  assign busy = (state == ST_ACTIVE);

  stream_demux_out_reg #(.DATA_W(DATA_W)) u_out0 (
    .clk     (clk),
    .rst     (rst),
    .load    (load0),
    .in_data (s_data),
    .in_last (s_last),
    .ready   (m0_ready),
    .valid   (m0_valid),
    .data    (m0_data),
    .last    (m0_last)
  );

  stream_demux_out_reg #(.DATA_W(DATA_W)) u_out1 (
    .clk     (clk),
    .rst     (rst),
    .load    (load1),
    .in_data (s_data),
    .in_last (s_last),
    .ready   (m1_ready),
    .valid   (m1_valid),
    .data    (m1_data),
    .last    (m1_last)
  );

`ifdef STREAM_DEMUX_PKT_CNT_EN
  // Count downstream handshakes that carry the last beat; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (m0_valid && m0_ready && m0_last) begin
        pkt_cnt0 <= pkt_cnt0 + 1'b1;
      end
      if (m1_valid && m1_ready && m1_last) begin
        pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
    end
  end
`else
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// tb_stream_demux_1to2: directed self-checking bench for stream_demux_1to2.
module tb_stream_demux_1to2;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_sel;
  logic              m0_valid, m0_ready, m0_last;
  logic [DATA_W-1:0] m0_data;
  logic              m1_valid, m1_ready, m1_last;
  logic [DATA_W-1:0] m1_data;
  logic              busy;
  logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stream_demux_1to2 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_sel    (s_sel),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m0_last  (m0_last),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .m1_last  (m1_last),
    .busy     (busy),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; registered outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held 2 cycles with a valid beat on the input.
    rst = 1'b1; s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0; s_sel = 1'b1;
    m0_ready = 1'b1; m1_ready = 1'b1;
    tick(); tick();
    chk("rst_m0_valid", m0_valid, 0);
    chk("rst_m1_valid", m1_valid, 0);
    chk("rst_m1_data", m1_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt0", pkt_cnt0, 0);
    chk("rst_cnt1", pkt_cnt1, 0);
    rst = 1'b0; s_valid = 1'b0;
    tick();
    chk("idle_m1_valid", m1_valid, 0);

    // Single-beat packets alternating ports.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_sel = i[0]; s_data = 8'h11 + 8'(i); s_last = 1'b1;
      #1;
      chk("single_s_ready", s_ready, 1);
      tick();
      if (i[0]) begin
        chk("single_m1_valid", m1_valid, 1);
        chk("single_m1_data", m1_data, 32'h11 + 32'(i));
        chk("single_m0_drained", m0_valid, 0);
      end else begin
        chk("single_m0_valid", m0_valid, 1);
        chk("single_m0_data", m0_data, 32'h11 + 32'(i));
        chk("single_m0_last", m0_last, 1);
      end
    end
    s_valid = 1'b0;
    tick();
    chk("single_end_m0", m0_valid, 0);
    chk("single_end_m1", m1_valid, 0);

    // Route lock: s_sel=1 on beat 0 only, all beats must reach m1.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_sel = (i == 0); s_data = 8'hA0 + 8'(i); s_last = (i == 3);
      tick();
      chk("lock_m1_valid", m1_valid, 1);
      chk("lock_m1_data", m1_data, 32'hA0 + 32'(i));
      chk("lock_m0_valid", m0_valid, 0);
      chk("lock_busy", busy, (i != 3) ? 1 : 0);
    end
    s_valid = 1'b0;
    tick();

    // Backpressure on port 0.
    m0_ready = 1'b0;
    s_valid = 1'b1; s_sel = 1'b0; s_data = 8'hB0; s_last = 1'b0;
    #1;
    chk("bp_first_ready", s_ready, 1);
    tick();
    chk("bp_m0_valid", m0_valid, 1);
    chk("bp_m0_data0", m0_data, 32'hB0);
    s_data = 8'hB1; s_sel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_s_ready_low", s_ready, 0);
      chk("bp_m0_hold", m0_data, 32'hB0);
      tick();
    end
    m0_ready = 1'b1;
    #1;
    chk("bp_release_ready", s_ready, 1);
    tick();
    chk("bp_m0_data1", m0_data, 32'hB1);
    chk("bp_m0_valid1", m0_valid, 1);
    chk("bp_m1_untouched", m1_valid, 0);
    s_data = 8'hB2; s_last = 1'b1;
    tick();
    chk("bp_m0_data2", m0_data, 32'hB2);
    chk("bp_busy_end", busy, 0);
    s_valid = 1'b0;
    tick();
    chk("bp_drained", m0_valid, 0);

    // Non-target stall: m1 full and blocked, port-0 packet flows.
    m1_ready = 1'b0;
    s_valid = 1'b1; s_sel = 1'b1; s_data = 8'hC0; s_last = 1'b1;
    tick();
    chk("nt_m1_loaded", m1_data, 32'hC0);
    for (int i = 0; i < 3; i++) begin
      s_sel = (i == 0) ? 1'b0 : 1'b1; s_data = 8'hD0 + 8'(i); s_last = (i == 2);
      #1;
      chk("nt_s_ready", s_ready, 1);
      tick();
      chk("nt_m0_valid", m0_valid, 1);
      chk("nt_m0_data", m0_data, 32'hD0 + 32'(i));
      chk("nt_m1_hold_valid", m1_valid, 1);
      chk("nt_m1_hold_data", m1_data, 32'hC0);
    end
    s_valid = 1'b0;
    tick();
    chk("nt_m0_drained", m0_valid, 0);
    chk("nt_m1_still", m1_valid, 1);
    m1_ready = 1'b1;
    tick();
    chk("nt_m1_drained", m1_valid, 0);

    // Reset mid-packet after beat 2 of a 5-beat port-1 packet.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_sel = 1'b1; s_data = 8'hE0 + 8'(i); s_last = 1'b0;
      tick();
    end
    chk("mid_busy_pre", busy, 1);
    chk("mid_m1_data_pre", m1_data, 32'hE2);
    rst = 1'b1; s_valid = 1'b0;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_m0_valid", m0_valid, 0);
    chk("mid_m1_valid", m1_valid, 0);
    rst = 1'b0;
    s_valid = 1'b1; s_sel = 1'b0; s_data = 8'hF0; s_last = 1'b1;
    tick();
    chk("mid_new_m0_valid", m0_valid, 1);
    chk("mid_new_m0_data", m0_data, 32'hF0);
    chk("mid_new_m1_valid", m1_valid, 0);
    s_valid = 1'b0;
    tick();

`ifdef STREAM_DEMUX_PKT_CNT_EN
    // Counter wrap: 256 port-0 packets return pkt_cnt0 to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    s_valid = 1'b1; s_sel = 1'b0; s_data = 8'h01; s_last = 1'b1;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    chk("cnt0_one", pkt_cnt0, 1);
    s_valid = 1'b1;
    for (int i = 0; i < 255; i++) tick();
    s_valid = 1'b0;
    tick(); tick();
    chk("cnt0_wrap", pkt_cnt0, 0);
    chk("cnt1_zero", pkt_cnt1, 0);
`else
    chk("cnt0_tied", pkt_cnt0, 0);
    chk("cnt1_tied", pkt_cnt1, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_1to2.md
Name: stream_demux_1to2

Overview:
- Packet-aware 1-to-2 stream demultiplexer with valid/ready handshake. It is the splitting counterpart to the lab's 2-to-1 select logic.
- One input stream is routed to output 0 or output 1. The route is chosen per packet by a select bit sampled on the first beat.
- Each output has a one-entry registered buffer, so every output is driven by a flop.
- Sits between a single producer and two consumers in the procedural-block lab series.

Parameters:
- DATA_W, 8, width of the data bus on input and both outputs.
- CNT_W, 8, width of the per-output packet counters (optional feature).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  input beat valid.
- s_ready  output  1  input beat accepted when s_valid && s_ready.
- s_data  input  DATA_W  input beat data.
- s_last  input  1  last beat of packet.
- s_sel  input  1  route select; sampled only on the first beat of a packet (0 = port 0, 1 = port 1).
- m0_valid  output  1  port 0 beat valid.
- m0_ready  input  1  port 0 consumer ready.
- m0_data  output  DATA_W  port 0 data.
- m0_last  output  1  port 0 last.
- m1_valid / m1_ready / m1_data / m1_last  same as port 0, for port 1.
- busy  output  1  high while in ACTIVE state (packet in progress).
- pkt_cnt0  output  CNT_W  packets completed on port 0 (optional feature).
- pkt_cnt1  output  CNT_W  packets completed on port 1 (optional feature).

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, route=0;
  - m0_valid=m1_valid=0, m0_data=m1_data=0, m0_last=m1_last=0;
  - pkt_cnt0=pkt_cnt1=0.
- Reset mid-packet discards any buffered beats and the partial packet; no recovery.
- Route:
  - In IDLE, the effective target is s_sel.
  - In ACTIVE, the effective target is the registered route; s_sel is ignored.
- Ready:
  - s_ready = !tgt_valid || tgt_ready, where tgt is the effective target's output register.
  - s_ready is combinational from state, route, s_sel and the target's m*_ready.
  - s_ready must not depend on s_valid.
- Accept (s_valid && s_ready):
  - the target register loads s_data and s_last and sets valid;
  - the non-target register is untouched.
- Output register, per port:
  - valid clears when m*_valid && m*_ready and no new load occurs that cycle;
  - simultaneous drain and load keeps valid=1 with the new data (full throughput, 1 beat/cycle).
- Latency: an accepted beat appears on m*_data exactly 1 cycle later.
- FSM:
  - IDLE → ACTIVE on an accepted beat with s_last=0; route <= s_sel.
  - IDLE stays IDLE on an accepted single-beat packet (s_last=1); route <= s_sel.
  - ACTIVE → IDLE on an accepted beat with s_last=1.
  - ACTIVE otherwise holds.
- busy = (state==ACTIVE).
- Switching ports between packets costs no bubble when the new target register is empty or draining.
- Backpressure on the non-target port never stalls the input.
- Producer contract: s_data, s_last and s_sel are held stable while s_valid=1 && s_ready=0. The block does not check this.

Optional Feature:
- Macro: STREAM_DEMUX_PKT_CNT_EN.
- Defined:
  - pkt_cnt0 / pkt_cnt1 increment by 1 on each downstream handshake with m*_last=1 on that port;
  - counters wrap 2^CNT_W−1 → 0; reset to 0.
- Undefined: the counter logic is removed; pkt_cnt0 and pkt_cnt1 are tied to 0.

Decomposition:
- Package stream_demux_pkg holds:
  - state encoding localparams ST_IDLE=1'b0, ST_ACTIVE=1'b1;
  - port index constants PORT0=1'b0, PORT1=1'b1.
- Sub-module stream_demux_out_reg is the one-entry output buffer (load, drain, valid/data/last regs). It is instantiated twice.
- The FSM, route register and counters stay in the top module.

Test Plan:
- Reset: drive rst=1 for 2 cycles with s_valid=1.
  - All m*_valid=0, busy=0, counters=0.
  - No beat accepted while rst=1.
- Single-beat packets: s_sel alternates 0,1,0,1, s_last=1, data 0x11..0x14, both m*_ready=1.
  - 0x11/0x13 on m0 and 0x12/0x14 on m1, each 1 cycle after accept.
  - s_ready stays 1 throughout.
- Multi-beat route lock: 4-beat packet 0xA0..0xA3 with s_sel=1 on beat 0, then s_sel=0 on beats 1–3.
  - All 4 beats on m1; busy=1 from after beat 0 until after beat 3.
- Backpressure: m0_ready=0 for 5 cycles during a port-0 packet.
  - s_ready=0 after the first buffered beat; m0_data is held stable.
  - No data lost or duplicated after m0_ready=1.
- Non-target stall: m1_ready=0 with a full m1 buffer, then a port-0 packet arrives.
  - The port-0 packet flows at 1 beat/cycle; the m1 beat is held.
- Reset mid-packet: assert rst after beat 2 of a 5-beat packet.
  - busy=0 and both m*_valid=0 next cycle.
  - The next packet routes by its own s_sel.
  - With STREAM_DEMUX_PKT_CNT_EN: 256 port-0 packets with CNT_W=8 leave pkt_cnt0 wrapped to 0.
